// File: rtl/multicycle_adder_pkg.sv
// multicycle_adder_pkg: FSM state encoding and counter-width helper shared by the multi-cycle adder
package multicycle_adder_pkg;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;
   // chunk counter needs at least one bit even when a single chunk covers the word
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/multicycle_adder_chunk.sv
// chunk_ripple_adder: combinational ripple of CHUNK full-adder cells
// Ports: a, b (CHUNK) operands; cin carry-in; sum (CHUNK); cout carry out of top bit;
//        c_msb carry into the top bit (for signed overflow detection)
module chunk_ripple_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);
   logic [CHUNK:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign cout  = c[CHUNK];
   assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: add/subtract unit processing CHUNK bits per cycle behind valid/ready handshakes
// Ports: clk_i clock; rst_i sync active-low reset; In_A/In_B operands; Carry_in carry/borrow-in;
//        Sub selects A-B-Carry_in; in_valid/in_ready operand handshake; Sum result;
//        Carry_out (sub: 1 = no borrow); Overflow signed overflow; Zero Sum==0;
//        out_valid/out_ready result handshake
module multicycle_adder
   import multicycle_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] In_A,
   input  logic [WIDTH-1:0] In_B,
   input  logic             Carry_in,
   input  logic             Sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry_out,
   output logic             Overflow,
   output logic             Zero,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = cnt_w(N);
   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK");
   end
   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_d, sum_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, ovf_q, zero_q;
   logic [CHUNK-1:0] chunk_sum;
   logic             chunk_cout, chunk_cmsb, last;
   chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_q[CHUNK-1:0]),
      .b    (b_q[CHUNK-1:0]),
      .cin  (carry_q),
      .sum  (chunk_sum),
      .cout (chunk_cout),
      .c_msb(chunk_cmsb)
   );
   // new chunk enters at the top; after N chunks the low chunk sits at bit 0
   assign res_d     = WIDTH'({chunk_sum, res_q} >> CHUNK);
   assign last      = cnt_q == CW'(N - 1);
   assign in_ready  = state_q == S_IDLE;
   assign out_valid = state_q == S_DONE;
   assign Sum       = sum_q;
   assign Carry_out = cout_q;
   assign Overflow  = ovf_q;
   assign Zero      = zero_q;
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               // subtraction is A + ~B + 1, folded with the borrow-in into the initial carry
               a_q     <= In_A;
               b_q     <= Sub ? ~In_B : In_B;
               carry_q <= Carry_in ^ Sub;
               cnt_q   <= '0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               a_q     <= a_q >> CHUNK;
               b_q     <= b_q >> CHUNK;
               res_q   <= res_d;
               carry_q <= chunk_cout;
               cnt_q   <= cnt_q + CW'(1);
               if (last) begin
                  sum_q   <= res_d;
                  cout_q  <= chunk_cout;
                  ovf_q   <= chunk_cmsb ^ chunk_cout;
                  zero_q  <= res_d == '0;
                  state_q <= S_DONE;
               end
            end
            S_DONE: if (out_ready) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: directed and random checks of the multi-cycle adder against an arithmetic model
module tb_multicycle_adder;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst_n;
   logic [31:0] a, b, sum;
   logic        cin, sub, iv, ir, co, ov, z, ovl, ordy;
   logic [7:0]  a8, b8, sum8;
   logic        cin8, sub8, iv8, ir8, co8, ov8, z8, ovl8, ordy8;
   int errors = 0, checks = 0;
   multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk_i(clk), .rst_i(rst_n), .In_A(a), .In_B(b), .Carry_in(cin), .Sub(sub),
      .in_valid(iv), .in_ready(ir), .Sum(sum), .Carry_out(co), .Overflow(ov), .Zero(z),
      .out_valid(ovl), .out_ready(ordy)
   );
   multicycle_adder #(.WIDTH(8), .CHUNK(1)) dut8 (
      .clk_i(clk), .rst_i(rst_n), .In_A(a8), .In_B(b8), .Carry_in(cin8), .Sub(sub8),
      .in_valid(iv8), .in_ready(ir8), .Sum(sum8), .Carry_out(co8), .Overflow(ov8), .Zero(z8),
      .out_valid(ovl8), .out_ready(ordy8)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   // returns {zero, overflow, carry_out, sum} from plain integer arithmetic
   function automatic logic [34:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                         input logic c, input logic s);
      longint ux = longint'(x), uy = longint'(y);
      longint sx = longint'($signed(x)), sy = longint'($signed(y));
      longint r, sr;
      logic [31:0] sm;
      logic cout, ovf;
      if (!s) begin
         r = ux + uy + longint'(c);
         sr = sx + sy + longint'(c);
         cout = r[32];
      end else begin
         r = ux - uy - longint'(c);
         sr = sx - sy - longint'(c);
         cout = r >= 0;
      end
      sm = r[31:0];
      ovf = sr != longint'($signed(sm));
      return {sm == 32'd0, ovf, cout, sm};
   endfunction
   task automatic op32(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic c, input logic s);
      logic [34:0] e;
      int lat;
      e = ref32(x, y, c, s);
      @(negedge clk);
      chk({tag, " in_ready idle"}, 64'(ir), 64'd1);
      a = x; b = y; cin = c; sub = s; iv = 1'b1;
      @(negedge clk);
      iv = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!ovl && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'd4);
      chk({tag, " sum"}, 64'(sum), 64'(e[31:0]));
      chk({tag, " carry"}, 64'(co), 64'(e[32]));
      chk({tag, " ovf"}, 64'(ov), 64'(e[33]));
      chk({tag, " zero"}, 64'(z), 64'(e[34]));
      chk({tag, " in_ready busy"}, 64'(ir), 64'd0);
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
      chk({tag, " out_valid drop"}, 64'(ovl), 64'd0);
   endtask
   task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic s,
                      input logic [7:0] es, input logic ec, input logic eo, input logic ez);
      int lat;
      @(negedge clk);
      a8 = x; b8 = y; cin8 = 1'b0; sub8 = s; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      lat = 0;
      while (!ovl8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'd8);
      chk({tag, " sum"}, 64'(sum8), 64'(es));
      chk({tag, " carry"}, 64'(co8), 64'(ec));
      chk({tag, " ovf"}, 64'(ov8), 64'(eo));
      chk({tag, " zero"}, 64'(z8), 64'(ez));
      ordy8 = 1'b1;
      @(negedge clk);
      ordy8 = 1'b0;
   endtask
   initial begin
      logic [34:0] e;
      int lat;
      rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; iv = 1'b0; ordy = 1'b0;
      a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b0; ordy8 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("reset in_ready", 64'(ir), 64'd1);
      chk("reset out_valid", 64'(ovl), 64'd0);
      chk("reset sum", 64'(sum), 64'd0);
      chk("reset flags", 64'({co, ov, z}), 64'd0);
      op32("t1 wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
      op32("t2 ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      op32("t3 5-7", 32'd5, 32'd7, 1'b0, 1'b1);
      op32("t3 7-5", 32'd7, 32'd5, 1'b0, 1'b1);
      // reset two chunks into RUN; previous result (2, carry 1) must be cleared
      @(negedge clk);
      a = 32'h1234_5678; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; iv = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("t5 rst sum", 64'(sum), 64'd0);
      chk("t5 rst flags", 64'({co, ov, z}), 64'd0);
      chk("t5 rst out_valid", 64'(ovl), 64'd0);
      chk("t5 rst in_ready", 64'(ir), 64'd1);
      op32("t5 3+4", 32'd3, 32'd4, 1'b0, 1'b0);
      // backpressure in DONE with in_valid asserted and operands changing
      e = ref32(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
      @(negedge clk);
      a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1; sub = 1'b0; iv = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      lat = 0;
      while (!ovl && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("t4 latency", 64'(lat), 64'd4);
      for (int i = 0; i < 3; i++) begin
         iv = 1'b1; a = $urandom; b = $urandom; sub = ~sub; cin = ~cin;
         @(negedge clk);
         chk("t4 hold sum", 64'(sum), 64'(e[31:0]));
         chk("t4 hold flags", 64'({z, ov, co}), 64'(e[34:32]));
         chk("t4 hold valid", 64'(ovl), 64'd1);
         chk("t4 hold in_ready", 64'(ir), 64'd0);
      end
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
      chk("t4 release in_ready", 64'(ir), 64'd1);
      chk("t4 release valid", 64'(ovl), 64'd0);
      iv = 1'b0;
      op32("edge min-1", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      op32("edge borrow", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
      op32("edge cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      op32("edge negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      for (int i = 0; i < 24; i++)
         op32("rnd", $urandom, $urandom, 1'($urandom), 1'($urandom));
      op8("t6 ff+1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      op8("t6 7f+1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
      op8("t6 3-5", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
